uart_rx_cmd_parser: RTL
=======================

Name: uart_rx_cmd_parser

Overview:
- Sits directly downstream of the UART receiver.
- Consumes the receiver's byte stream (data, valid pulse, parity/stop error flags) and assembles multi-byte command frames.
- Issues single-cycle register-file write/read strobes or ALU enable strobes, with registered address, data, operands and function.
- Acts as the RX-side front end of the system controller.

Parameters:
DATA_WIDTH, 8, byte width of received data, write data and ALU operands
ADDR_WIDTH, 4, register-file address width; taken from the address byte's LSBs
FUNC_WIDTH, 4, ALU function width; taken from the function byte's LSBs
TIMEOUT_CYCLES, 1024, inter-byte timeout in clocks; used only with PARSER_TIMEOUT_EN

Ports:
i_CLK  in  1  parser clock
i_RST  in  1  synchronous, active-high reset
i_RX_Data  in  DATA_WIDTH  received byte; valid only with i_RX_Valid
i_RX_Valid  in  1  one-cycle pulse per received byte, already synchronised to i_CLK
i_par_err  in  1  parity error qualifier for the current byte
i_stp_err  in  1  stop-bit error qualifier for the current byte
i_busy  in  1  downstream stall; holds a completed command in ISSUE
o_WrEn  out  1  register write strobe, one cycle
o_RdEn  out  1  register read strobe, one cycle
o_Addr  out  ADDR_WIDTH  register address
o_WrData  out  DATA_WIDTH  register write data
o_ALU_OpA  out  DATA_WIDTH  ALU operand A
o_ALU_OpB  out  DATA_WIDTH  ALU operand B
o_ALU_Fun  out  FUNC_WIDTH  ALU function
o_ALU_En  out  1  ALU enable strobe, one cycle
o_frame_err  out  1  one-cycle pulse: frame aborted
o_cmd_err  out  1  one-cycle pulse: bad opcode or byte dropped in ISSUE

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Operand registers 0.
  - Reset mid-frame discards the partial frame; no strobe is issued.
- Opcodes, accepted in IDLE only:
  - 0xAA: write; then addr, data (3 bytes total).
  - 0xBB: read; then addr (2 bytes).
  - 0xCC: ALU with operands; then A, B, fun (4 bytes).
  - 0xDD: ALU without operands; then fun (2 bytes); reuses held OpA/OpB.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN, ISSUE.
- Transitions advance only on an i_RX_Valid cycle:
  - IDLE -> WR_ADDR | RD_ADDR | ALU_A | ALU_FUN, by opcode.
  - WR_ADDR -> WR_DATA -> ISSUE.
  - RD_ADDR -> ISSUE.
  - ALU_A -> ALU_B -> ALU_FUN -> ISSUE.
- Field capture:
  - Each byte is registered into its field on the edge that samples it.
  - o_Addr = byte[ADDR_WIDTH-1:0].
  - o_ALU_Fun = byte[FUNC_WIDTH-1:0].
  - Upper bits are ignored, not flagged.
- Unknown opcode in IDLE: byte dropped, o_cmd_err pulses one cycle, state stays IDLE.
- Error byte (i_RX_Valid with i_par_err or i_stp_err high):
  - Error takes priority over decoding.
  - Any state except ISSUE goes to IDLE, partial frame discarded, o_frame_err pulses one cycle.
  - In IDLE, the byte is dropped with an o_frame_err pulse.
- ISSUE:
  - On the first edge with i_busy=0, the matching strobe (o_WrEn, o_RdEn or o_ALU_En) is registered high for exactly one cycle and state returns to IDLE.
  - Latency: last byte valid at cycle k -> ISSUE at k+1 -> strobe high in cycle k+2 if i_busy=0 at k+1.
  - Each cycle of i_busy=1 adds one cycle.
- i_RX_Valid during ISSUE: byte dropped, o_cmd_err pulses; an error-flagged byte pulses o_frame_err instead. The pending command is still issued.
- Field outputs hold their values between commands.
- Strobes are never asserted together and never for more than one cycle.
- Byte arriving in the same cycle a strobe is issued (state now IDLE): decoded normally as an opcode.

Optional Feature:
PARSER_TIMEOUT_EN
- Defined:
  - A counter clears on every i_RX_Valid and on entry to IDLE.
  - It increments each cycle while in a mid-frame state (not IDLE, not ISSUE).
  - On reaching TIMEOUT_CYCLES-1: go to IDLE, discard the frame, o_frame_err pulses one cycle.
  - A byte arriving in that same cycle loses to the timeout and is dropped.
- Undefined: no counter, and a partial frame waits indefinitely.

Test Plan:
- 0xAA, 0x05, 0x3C, i_busy=0 -> o_WrEn one cycle, o_Addr=5, o_WrData=0x3C, k+2 latency from the last byte.
- 0xBB, 0x1F -> o_RdEn one cycle, o_Addr=0xF (upper bits dropped); 0xCC, 0x0A, 0x03, 0x01 -> o_ALU_En, OpA=0x0A, OpB=0x03, Fun=1; then 0xDD, 0x02 -> o_ALU_En, OpA/OpB unchanged, Fun=2.
- 0xAA, 0x02, then a data byte with i_par_err=1 -> o_frame_err pulse, no o_WrEn, state IDLE; next 0xBB, 0x02 decodes normally.
- 0xBB, 0x04 with i_busy=1 for 5 cycles, plus one byte 0x77 in ISSUE -> o_cmd_err pulse, o_RdEn high exactly one cycle after i_busy falls, o_Addr=4.
- Opcode 0x55 -> o_cmd_err pulse, no strobes; i_RST asserted after 0xCC, 0x01 -> outputs 0, no o_ALU_En.
- PARSER_TIMEOUT_EN, TIMEOUT_CYCLES=16: 0xAA then silence -> o_frame_err pulse 16 cycles after 0xAA, state IDLE; without the macro no pulse.

Source files
------------

// File: rtl/uart_rx_cmd_parser.sv
// uart_rx_cmd_parser: assembles UART RX bytes into register/ALU command strobes; optional inter-byte timeout under PARSER_TIMEOUT_EN
module uart_rx_cmd_parser #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int FUNC_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic [DATA_WIDTH-1:0] i_RX_Data,
   input  logic                  i_RX_Valid,
   input  logic                  i_par_err,
   input  logic                  i_stp_err,
   input  logic                  i_busy,
   output logic                  o_WrEn,
   output logic                  o_RdEn,
   output logic [ADDR_WIDTH-1:0] o_Addr,
   output logic [DATA_WIDTH-1:0] o_WrData,
   output logic [DATA_WIDTH-1:0] o_ALU_OpA,
   output logic [DATA_WIDTH-1:0] o_ALU_OpB,
   output logic [FUNC_WIDTH-1:0] o_ALU_Fun,
   output logic                  o_ALU_En,
   output logic                  o_frame_err,
   output logic                  o_cmd_err
);
   typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN, ISSUE} state_t;
   typedef enum logic [1:0] {CMD_WR, CMD_RD, CMD_ALU} cmd_t;
   localparam logic [DATA_WIDTH-1:0] OP_WR  = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] OP_RD  = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] OP_ALU = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] OP_FUN = DATA_WIDTH'(8'hDD);
   state_t state, state_n;
   cmd_t   cmd, cmd_n;
   logic   wr_en_n, rd_en_n, alu_en_n, frame_err_n, cmd_err_n;
   logic   cap_addr, cap_data, cap_a, cap_b, cap_fun;
   logic   rx_err, tmo;
   assign rx_err = i_par_err | i_stp_err;
`ifdef PARSER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_cnt;
   logic             mid_frame;
   assign mid_frame = (state != IDLE) && (state != ISSUE);
   assign tmo = mid_frame && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   // inter-byte silence counter; idles at zero outside mid-frame states
   always_ff @(posedge i_CLK) begin
      if (i_RST || i_RX_Valid || !mid_frame) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + 1'b1;
   end
`else
   assign tmo = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif
   // state and pending-command register
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state <= IDLE;
         cmd   <= CMD_WR;
      end else begin
         state <= state_n;
         cmd   <= cmd_n;
      end
   end
   // next state, strobe and capture decisions; timeout beats errors beats decoding
   always_comb begin
      state_n     = state;
      cmd_n       = cmd;
      wr_en_n     = 1'b0;
      rd_en_n     = 1'b0;
      alu_en_n    = 1'b0;
      frame_err_n = 1'b0;
      cmd_err_n   = 1'b0;
      cap_addr    = 1'b0;
      cap_data    = 1'b0;
      cap_a       = 1'b0;
      cap_b       = 1'b0;
      cap_fun     = 1'b0;
      if (tmo) begin
         state_n     = IDLE;
         frame_err_n = 1'b1;
      end else if (state == ISSUE) begin
         frame_err_n = i_RX_Valid & rx_err;
         cmd_err_n   = i_RX_Valid & ~rx_err;
         if (!i_busy) begin
            state_n  = IDLE;
            wr_en_n  = cmd == CMD_WR;
            rd_en_n  = cmd == CMD_RD;
            alu_en_n = cmd == CMD_ALU;
         end
      end else if (i_RX_Valid) begin
         if (rx_err) begin
            state_n     = IDLE;
            frame_err_n = 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  case (i_RX_Data)
                     OP_WR:  begin state_n = WR_ADDR; cmd_n = CMD_WR;  end
                     OP_RD:  begin state_n = RD_ADDR; cmd_n = CMD_RD;  end
                     OP_ALU: begin state_n = ALU_A;   cmd_n = CMD_ALU; end
                     OP_FUN: begin state_n = ALU_FUN; cmd_n = CMD_ALU; end
                     default: cmd_err_n = 1'b1;
                  endcase
               end
               WR_ADDR: begin cap_addr = 1'b1; state_n = WR_DATA; end
               WR_DATA: begin cap_data = 1'b1; state_n = ISSUE;   end
               RD_ADDR: begin cap_addr = 1'b1; state_n = ISSUE;   end
               ALU_A:   begin cap_a    = 1'b1; state_n = ALU_B;   end
               ALU_B:   begin cap_b    = 1'b1; state_n = ALU_FUN; end
               ALU_FUN: begin cap_fun  = 1'b1; state_n = ISSUE;   end
               default: state_n = IDLE;
            endcase
         end
      end
   end
   // registered strobes, error pulses and held command fields
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         o_WrEn      <= 1'b0;
         o_RdEn      <= 1'b0;
         o_ALU_En    <= 1'b0;
         o_frame_err <= 1'b0;
         o_cmd_err   <= 1'b0;
         o_Addr      <= '0;
         o_WrData    <= '0;
         o_ALU_OpA   <= '0;
         o_ALU_OpB   <= '0;
         o_ALU_Fun   <= '0;
      end else begin
         o_WrEn      <= wr_en_n;
         o_RdEn      <= rd_en_n;
         o_ALU_En    <= alu_en_n;
         o_frame_err <= frame_err_n;
         o_cmd_err   <= cmd_err_n;
         o_Addr      <= cap_addr ? i_RX_Data[ADDR_WIDTH-1:0] : o_Addr;
         o_WrData    <= cap_data ? i_RX_Data : o_WrData;
         o_ALU_OpA   <= cap_a ? i_RX_Data : o_ALU_OpA;
         o_ALU_OpB   <= cap_b ? i_RX_Data : o_ALU_OpB;
         o_ALU_Fun   <= cap_fun ? i_RX_Data[FUNC_WIDTH-1:0] : o_ALU_Fun;
      end
   end
endmodule
